// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO in front of a UART transmitter. One byte is popped per
// frame and handed over with a single-cycle start pulse.
//
// state     | meaning
// IDLE      | no frame owned; pop the head once data is queued and the line is free
// WAIT_DONE | frame launched; hold off further pops until done_tx
module uart_tx_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [7:0]        wr_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              start,
    output logic [7:0]        tx_data_in,
    input  logic              tx_active,
    input  logic              done_tx
);
    typedef enum logic {IDLE, WAIT_DONE} state_t;

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

    state_t            state_q, state_d;
    logic [7:0]        mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              start_q, start_d;
    logic              overflow_q, overflow_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              wr_acc;
    logic              pop;

    assign full       = (count_q == FULL_CNT);
    assign empty      = (count_q == '0);
    assign count      = count_q;
    assign overflow   = overflow_q;
    assign start      = start_q;
    assign tx_data_in = tx_data_q;

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        tx_data_d  = tx_data_q;
        start_d    = 1'b0;
        // full is registered, so a write dropped at full stays dropped even if a pop frees a slot
        wr_acc     = wr_en && !full;
        overflow_d = wr_en && full;
        pop        = (state_q == IDLE) && !empty && !tx_active;

        case (state_q)
            IDLE: begin
                if (pop) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (done_tx) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (pop) begin
            start_d   = 1'b1;
            tx_data_d = mem_q[rd_ptr_q];
            rd_ptr_d  = rd_ptr_q + ADDR_W'(1);
        end
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end

        case ({wr_acc, pop})
            2'b10:   count_d = count_q + (ADDR_W+1)'(1);
            2'b01:   count_d = count_q - (ADDR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            start_q    <= 1'b0;
            overflow_q <= 1'b0;
            tx_data_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            start_q    <= start_d;
            overflow_q <= overflow_d;
            tx_data_q  <= tx_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && wr_acc) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a queue-based model of the FIFO plus a frame-emulating
// transmitter; outputs are compared against the model every cycle.
module tb_uart_tx_fifo;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              rst, wr_en, tx_active, done_tx;
    logic [7:0]        wr_data;
    logic              full, empty, overflow, start;
    logic [ADDR_W:0]   count;
    logic [7:0]        tx_data_in;

    uart_tx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
        .full(full), .empty(empty), .count(count), .overflow(overflow),
        .start(start), .tx_data_in(tx_data_in),
        .tx_active(tx_active), .done_tx(done_tx)
    );

    always #5 clk = ~clk;

    // model: queued bytes, whether a frame is owned, and the expected registered outputs
    logic [7:0] mq[$];
    bit         m_in_frame;
    bit         exp_start, exp_ovf;
    logic [7:0] exp_tx;
    bit         chk_en = 1'b0;
    bit         rand_line = 1'b0;
    int         emu_left = 0;
    int         n_assert = 0, n_fail = 0;
    logic [7:0] tx_log[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit m_full, m_pop;
        if (rst) begin
            mq.delete();
            m_in_frame = 1'b0;
            exp_start  = 1'b0;
            exp_ovf    = 1'b0;
            exp_tx     = 8'h00;
        end else begin
            m_full    = (mq.size() == DEPTH);
            m_pop     = !m_in_frame && (mq.size() > 0) && !tx_active;
            exp_ovf   = wr_en && m_full;
            exp_start = m_pop;
            if (m_pop) begin
                exp_tx     = mq.pop_front();
                m_in_frame = 1'b1;
            end else if (m_in_frame && done_tx) begin
                m_in_frame = 1'b0;
            end
            if (wr_en && !m_full) mq.push_back(wr_data);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    // transmitter emulation, reacting to the model's start
    task automatic emu_drive();
        done_tx = 1'b0;
        if (exp_start) begin
            emu_left  = $urandom_range(1, 5);
            tx_active = 1'b1;
        end else if (emu_left > 0) begin
            emu_left--;
            if (emu_left == 0) begin
                tx_active = 1'b0;
                done_tx   = 1'b1;
            end
        end else begin
            tx_active = rand_line && ($urandom_range(0, 7) == 0);
            if (rand_line && ($urandom_range(0, 15) == 0)) done_tx = 1'b1;
        end
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (!(mq.size() == 0 && !m_in_frame && emu_left == 0)) begin
            step();
            emu_drive();
            n++;
            if (n > 600) begin
                n_assert++;
                n_fail++;
                $display("FAIL %s_timeout: drain still busy after %0d cycles", name, n);
                break;
            end
        end
        done_tx   = 1'b0;
        tx_active = 1'b0;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("count", count, mq.size());
            chk("full", full, mq.size() == DEPTH);
            chk("empty", empty, mq.size() == 0);
            chk("start", start, exp_start);
            chk("tx_data_in", tx_data_in, exp_tx);
            chk("overflow", overflow, exp_ovf);
            if (start === 1'b1) tx_log.push_back(tx_data_in);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int nxt;
        rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00; tx_active = 1'b0; done_tx = 1'b0;
        step();
        chk_en = 1'b1;
        step();
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_start", start, 0);
        chk("rst_tx", tx_data_in, 8'h00);
        chk("rst_ovf", overflow, 0);
        rst = 1'b0;

        // single byte: start lands one edge after the write edge
        wr_en = 1'b1; wr_data = 8'hA5; step(); wr_en = 1'b0;
        chk("sb_count1", count, 1);
        chk("sb_nostart", start, 0);
        step();
        chk("sb_start", start, 1);
        chk("sb_data", tx_data_in, 8'hA5);
        chk("sb_count0", count, 0);
        tx_active = 1'b1; wr_en = 1'b1; wr_data = 8'h3C; step(); wr_en = 1'b0;
        chk("sb_start_once", start, 0);
        tx_active = 1'b0;
        repeat (3) step();
        chk("sb_wait_count", count, 1);
        chk("sb_wait_start", start, 0);
        done_tx = 1'b1; step(); done_tx = 1'b0;
        chk("sb_done_nostart", start, 0);
        step();
        chk("sb_next_start", start, 1);
        chk("sb_next_data", tx_data_in, 8'h3C);
        done_tx = 1'b1; step(); done_tx = 1'b0;

        // overflow with the line held busy
        tx_log.delete();
        tx_active = 1'b1;
        for (int i = 0; i < 17; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'h40 + i); step();
            if (i == 15) begin
                chk("ovf_full16", full, 1);
                chk("ovf_count16", count, 16);
                chk("ovf_none_yet", overflow, 0);
            end
        end
        wr_en = 1'b0;
        chk("ovf_pulse", overflow, 1);
        chk("ovf_count", count, 16);
        step();
        chk("ovf_once", overflow, 0);
        // write at full while a pop happens: write dropped
        wr_en = 1'b1; wr_data = 8'hEE; tx_active = 1'b0; step();
        wr_en = 1'b0; tx_active = 1'b1; emu_left = 2;
        chk("fp_start", start, 1);
        chk("fp_data", tx_data_in, 8'h40);
        chk("fp_ovf", overflow, 1);
        chk("fp_count", count, 15);
        drain("fp");
        chk("fp_log_len", tx_log.size(), 16);
        for (int i = 0; i < 16 && i < tx_log.size(); i++) chk("fp_log", tx_log[i], 8'(8'h40 + i));

        // write and pop together at count=1
        tx_log.delete();
        tx_active = 1'b1; wr_en = 1'b1; wr_data = 8'h11; step();
        wr_data = 8'h22; tx_active = 1'b0; step();
        wr_en = 1'b0; tx_active = 1'b1; emu_left = 3;
        chk("c1_start", start, 1);
        chk("c1_data", tx_data_in, 8'h11);
        chk("c1_count", count, 1);
        drain("c1");
        chk("c1_log_len", tx_log.size(), 2);
        if (tx_log.size() == 2) chk("c1_second", tx_log[1], 8'h22);

        // stray done_tx in IDLE with the line busy
        tx_active = 1'b1; wr_en = 1'b1; wr_data = 8'h77; step(); wr_en = 1'b0;
        repeat (4) begin
            done_tx = 1'b1; step(); done_tx = 1'b0;
            chk("stray_nostart", start, 0);
        end
        tx_active = 1'b0; step();
        chk("stray_start", start, 1);
        chk("stray_data", tx_data_in, 8'h77);
        tx_active = 1'b1; emu_left = 2;
        drain("stray");

        // reset mid-frame, also colliding with a write
        tx_active = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'h81 + i); step();
        end
        wr_en = 1'b0; tx_active = 1'b0; step();
        chk("rm_start", start, 1);
        chk("rm_data", tx_data_in, 8'h81);
        tx_active = 1'b1;
        rst = 1'b1; wr_en = 1'b1; wr_data = 8'h99; step();
        rst = 1'b0; wr_en = 1'b0; tx_active = 1'b0; emu_left = 0;
        chk("rm_count", count, 0);
        chk("rm_start0", start, 0);
        chk("rm_tx0", tx_data_in, 8'h00);
        repeat (5) begin
            step();
            chk("rm_no_start", start, 0);
        end
        wr_en = 1'b1; wr_data = 8'h5A; step(); wr_en = 1'b0; step();
        chk("rm_restart", start, 1);
        chk("rm_restart_data", tx_data_in, 8'h5A);
        tx_active = 1'b1; emu_left = 2;
        drain("rm");

        // ordering and pointer wrap: 0x00..0x13 interleaved with emulated frames
        tx_log.delete();
        nxt = 0;
        for (int c = 0; c < 3000; c++) begin
            wr_en   = (nxt < 20) && (mq.size() < DEPTH) && ($urandom_range(0, 1) == 1);
            wr_data = 8'(nxt);
            step();
            if (wr_en) nxt++;
            wr_en = 1'b0;
            emu_drive();
            if (nxt == 20 && mq.size() == 0 && !m_in_frame && emu_left == 0) break;
        end
        drain("wrap");
        chk("wrap_log_len", tx_log.size(), 20);
        for (int i = 0; i < 20 && i < tx_log.size(); i++) chk("wrap_order", tx_log[i], 8'(i));

        // random traffic with line noise, stray done_tx and occasional reset
        rand_line = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            rst     = ($urandom_range(0, 499) == 0);
            wr_en   = ($urandom_range(0, 2) != 0);
            wr_data = 8'($urandom);
            step();
            if (rst) emu_left = 0;
            rst = 1'b0;
            emu_drive();
        end
        rand_line = 1'b0;
        wr_en = 1'b0;
        drain("rand");
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter: DEPTH, default 16, FIFO entries; SHALL be a power of two, 2..256.
REQ-002 Parameter: ADDR_W, default 4, pointer width; SHALL equal log2(DEPTH).
REQ-003 Port: clk  input  1  single clock; all logic SHALL be on its rising edge.
REQ-004 Port: rst  input  1  reset; SHALL be synchronous and active-high.
REQ-005 Port: wr_en  input  1  write strobe; one byte per cycle when high.
REQ-006 Port: wr_data  input  8  byte to enqueue.
REQ-007 Port: full  output  1  high when count == DEPTH.
REQ-008 Port: empty  output  1  high when count == 0.
REQ-009 Port: count  output  ADDR_W+1  number of bytes stored.
REQ-010 Port: overflow  output  1  one-cycle pulse; a write was dropped.
REQ-011 Port: start  output  1  one-cycle pulse to the transmitter; begins a frame.
REQ-012 Port: tx_data_in  output  8  byte to transmit; valid with start and held until the next start.
REQ-013 Port: tx_active  input  1  from the transmitter; high while a frame is on the line.
REQ-014 Port: done_tx  input  1  from the transmitter; one-cycle pulse at frame end.

Function
REQ-015 Storage: DEPTH x 8 circular buffer; rd_ptr and wr_ptr are ADDR_W bits and SHALL wrap from DEPTH-1 to 0.
REQ-016 count SHALL be a separate registered counter: +1 on accepted write only, -1 on pop only, unchanged when both or neither occur.
REQ-017 full, empty and count SHALL be registered-state derived, with no combinational path from wr_en.
REQ-018 Write accepted iff wr_en=1 and full=0: mem[wr_ptr]<=wr_data, then wr_ptr++.
REQ-019 Write with full=1 SHALL be dropped, leave pointers and count unchanged, and assert overflow for exactly the next cycle; this holds even if a pop occurs in the same cycle.
REQ-020 FSM states: IDLE and WAIT_DONE.
REQ-021 IDLE with empty=0 and tx_active=0: at the edge start<=1, tx_data_in<=mem[rd_ptr], rd_ptr++, count decrements (pop), and the state SHALL go to WAIT_DONE.
REQ-022 IDLE with empty=1 or tx_active=1: SHALL stay in IDLE with start=0.
REQ-023 WAIT_DONE: start SHALL be 0 from the second cycle onward; on done_tx=1 the state SHALL return to IDLE; otherwise it SHALL stay.
REQ-024 At most one pop SHALL occur per frame; start SHALL never be high on two consecutive cycles.
REQ-025 Minimum latency: byte written at edge N into an empty FIFO with the transmitter idle -> start=1 in the cycle after edge N+1.
REQ-026 Back-to-back frames: after done_tx returns the FSM to IDLE, the next start SHALL be issued at the first edge where tx_active=0 and empty=0.
REQ-027 Simultaneous write and pop at full: the pop SHALL proceed, the write SHALL be dropped, and count SHALL become DEPTH-1.
REQ-028 Simultaneous write and pop at count=1: the pop SHALL take the old head, the new byte SHALL be stored, and count SHALL remain 1.
REQ-029 done_tx received in IDLE SHALL be ignored.
REQ-030 tx_data_in SHALL hold its value between starts and SHALL not change while tx_active=1.

Reset
REQ-031 While rst=1 at an edge: rd_ptr=0, wr_ptr=0, count=0, state=IDLE, start=0, tx_data_in=8'h00, overflow=0; therefore empty=1 and full=0.
REQ-032 Reset SHALL take priority over every write and pop in the same cycle.
REQ-033 Reset mid-frame SHALL discard all stored bytes and return the FSM to IDLE.
REQ-034 Memory contents need no reset.

Verification
REQ-035 Single byte: reset, write 8'hA5, tx_active=0 -> start pulses 1 cycle later with tx_data_in=8'hA5, count 1->0, FSM in WAIT_DONE until done_tx.
REQ-036 Ordering and wrap: DEPTH=16; write 8'h00..8'h13 interleaved with 20 emulated frames -> start values appear in order 00..13, pointers wrap, and no overflow occurs.
REQ-037 Overflow: hold tx_active=1, write 17 bytes -> full=1 after 16 writes, overflow pulses once on the 17th, count=16, and the 17th byte is never transmitted.
REQ-038 Simultaneous events: at count=16 in IDLE, drive wr_en and release tx_active -> pop occurs, overflow=1, count=15; at count=1, drive write and pop together -> count stays 1 and order is preserved.
REQ-039 Reset mid-frame: 3 bytes queued, first frame active, assert rst -> count=0, start=0, tx_data_in=8'h00, and no further start until a new write.
REQ-040 Stray done_tx in IDLE with data queued and tx_active=1 -> no start; start is issued only after tx_active falls.
